draw_sweep_arbiter: RTL and testbench
=====================================

# draw_sweep_arbiter

Sequencer and two-way arbiter for the draw memory's dual write ports. It accepts rectangular-free linear "sweep" jobs from two requesters (e.g. clear engine and draw engine), grants one at a time, and walks the job's region as even/odd address pairs. Port A writes the even address and port B writes the odd address of each pair in the same cycle. It sits between the draw requesters and the dual-port frame memory, replacing free-running address counters with job-driven sequencing.

## Interface
- ADDR_W, 14, memory word address width; pair index width is ADDR_W-1
- DATA_W, 8, write data width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  job request from requester 0 / 1, held high until matching gnt
- base0 / base1  in  ADDR_W-1  first pair index of the job
- len0 / len1  in  ADDR_W  number of pairs to write (0 allowed)
- data0 / data1  in  DATA_W  fill value for the job
- gnt0 / gnt1  out  1  one-cycle grant pulse
- done0 / done1  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after acceptance through the done cycle
- stall  in  1  memory back-pressure: no write this cycle, sequence holds
- addr_a / addr_b  out  ADDR_W  {pair, 1'b0} / {pair, 1'b1}
- we_a / we_b  out  1  write enables, always equal
- wdata_a / wdata_b  out  DATA_W  latched job data

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if req0 or req1 is high at an edge, the arbiter picks the owner, then latches base, len, data and owner, and clears idx. The next state is RUN if len>0, else DONE.
- Arbitration is round-robin using a last-owner pointer. The pointer resets to 1, so requester 0 wins the first tie. The pointer updates to the owner on acceptance.
- RUN: pair = (base + idx) mod 2^(ADDR_W-1), so addresses wrap at the top of memory.
  - With stall=0: we_a=we_b=1 and idx increments. When idx reaches len-1 on a non-stalled cycle, the next state is DONE.
  - With stall=1: we low; addr, wdata and idx hold.
- DONE: done<owner>=1 for exactly one cycle, with we low. The next state is IDLE.
- req is sampled only in IDLE. A req dropped before it is granted is forgotten. Job fields are sampled only at the acceptance edge. While busy, reqs are ignored and no gnt is issued.
- Outside RUN: we_a=we_b=0. addr_a, addr_b, wdata_a and wdata_b hold their last values (don't-care).
- Reset (any state, including mid-RUN): state IDLE, idx 0, pointer 1, and all outputs 0 (addr, wdata, we, gnt, done, busy). An aborted job produces no done.
- len uses ADDR_W bits so a full sweep (len=2^(ADDR_W-1)) is expressible. Larger len wraps and rewrites pairs; this is permitted and not flagged.

## Timing
- Acceptance edge at end of cycle N.
- Cycle N+1: gnt<owner>=1, busy=1. If len>0, the first write (idx 0) is also in cycle N+1, giving zero-cycle grant-to-write latency.
- len=L with no stall: writes occur in cycles N+1..N+L. done in cycle N+L+1. IDLE and busy=0 in cycle N+L+2, which can itself be an acceptance cycle.
- len=0: gnt and done both high in cycle N+1, with no writes. busy=0 in N+2.
- Each stall cycle in RUN delays done by one cycle.
- Job throughput is L+2 cycles per job, back-to-back.

## Configuration
- DRAW_SWEEP_RR_EN defined: round-robin arbitration as described.
- DRAW_SWEEP_RR_EN undefined: fixed priority, where requester 0 always wins when both are requesting. The pointer logic is removed.
- All other behaviour is identical in both builds.

## Test plan
- Single job: req0 with base0=1024, len0=4, data0=0xAA, accepted at N.
  - Cycles N+1..N+4: addr_a=2048,2050,2052,2054 and addr_b=2049..2055, we high, wdata=0xAA.
  - gnt0 at N+1, done0 at N+5, busy low at N+6.
- Contention: req0 and req1 held high continuously, each with len=2.
  - RR build: grant order 0,1,0,1.
  - Fixed-priority build: 0,0,0.
  - In both builds, no gnt is issued while busy.
- Wrap and stall: base=8191, len=2, stall high for one cycle after the first write.
  - Pair sequence 8191, (hold), 0: addr_a=16382 then 0, and addr_b=16383 then 1.
  - done one cycle later than in the unstalled case.
- Zero length: req1 with len1=0 gives gnt1 and done1 in the same cycle, no we, and busy for exactly 1 cycle.
- Reset mid-run: reset asserted during the third write of an 8-pair job.
  - The next cycle has all outputs 0 and no done.
  - A subsequent req0 is accepted normally, and in the RR build requester 0 wins a tie.

Source files
------------

// File: rtl/draw_sweep_arbiter.sv
// draw_sweep_arbiter: two-requester sweep-job arbiter and even/odd pair
// sequencer for the dual write ports of the draw frame memory.
// Build option: define DRAW_SWEEP_RR_EN for round-robin arbitration;
// leave it undefined for fixed priority (requester 0 wins ties).
module draw_sweep_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-2:0] base0,
  input  logic [ADDR_W-2:0] base1,
  input  logic [ADDR_W-1:0] len0,
  input  logic [ADDR_W-1:0] len1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              we_a,
  output logic              we_b,
  output logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] wdata_b
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] IDX_ONE  = 1;
  localparam logic [ADDR_W-2:0] PAIR_ONE = 1;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] len_reg;
  logic              owner_reg;
  logic [ADDR_W-1:0] addr_a_reg;
  logic [ADDR_W-1:0] addr_b_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              gnt0_reg;
  logic              gnt1_reg;

  logic              accept;
  logic              pick1;
  logic [ADDR_W-2:0] sel_base;
  logic [ADDR_W-1:0] sel_len;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-2:0] cur_pair;
  logic              write_now;
  logic              last_pair;

  // Requests are only looked at while idle; busy masks them entirely.
  assign accept = (state_reg == ST_IDLE) && (req0 || req1);

`ifdef DRAW_SWEEP_RR_EN
  logic ptr_reg;

  // Round-robin: on a tie the requester that did not own the last job wins.
  assign pick1 = req1 && (!req0 || !ptr_reg);

  // Last-owner pointer; reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 1'b1;
    end else if (accept) begin
      ptr_reg <= pick1;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is quiet.
  assign pick1 = req1 && !req0;
`endif

  assign sel_base = pick1 ? base1 : base0;
  assign sel_len  = pick1 ? len1  : len0;
  assign sel_data = pick1 ? data1 : data0;

  // The even address register always carries the current pair index.
  assign cur_pair  = addr_a_reg[ADDR_W-1:1];
  assign write_now = (state_reg == ST_RUN) && !stall;
  assign last_pair = (idx_reg == (len_reg - IDX_ONE));

  // Job sequencer: accept, walk pairs (holding on stall), then pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      len_reg    <= '0;
      owner_reg  <= 1'b0;
      addr_a_reg <= '0;
      addr_b_reg <= '0;
      wdata_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            owner_reg <= pick1;
            len_reg   <= sel_len;
            idx_reg   <= '0;
            if (sel_len != '0) begin
              // Address and data are presented in the grant cycle itself.
              addr_a_reg <= {sel_base, 1'b0};
              addr_b_reg <= {sel_base, 1'b1};
              wdata_reg  <= sel_data;
              state_reg  <= ST_RUN;
            end else begin
              state_reg  <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (write_now) begin
            if (last_pair) begin
              // Keep the last address on the bus; it is don't-care from here.
              state_reg <= ST_DONE;
            end else begin
              // Pair index wraps naturally in ADDR_W-1 bits.
              idx_reg    <= idx_reg + IDX_ONE;
              addr_a_reg <= {cur_pair + PAIR_ONE, 1'b0};
              addr_b_reg <= {cur_pair + PAIR_ONE, 1'b1};
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant pulses are registered so they line up with the first write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0_reg <= 1'b0;
      gnt1_reg <= 1'b0;
    end else begin
      gnt0_reg <= accept && !pick1;
      gnt1_reg <= accept && pick1;
    end
  end

  assign gnt0    = gnt0_reg;
  assign gnt1    = gnt1_reg;
  assign done0   = (state_reg == ST_DONE) && !owner_reg;
  assign done1   = (state_reg == ST_DONE) && owner_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign we_a    = write_now;
  assign we_b    = write_now;
  assign addr_a  = addr_a_reg;
  assign addr_b  = addr_b_reg;
  assign wdata_a = wdata_reg;
  assign wdata_b = wdata_reg;

endmodule

// File: tb/tb_draw_sweep_arbiter.sv
// Bench for draw_sweep_arbiter: per-cycle expected bus state is queued when a
// job is driven and compared on the falling edge as cycles elapse.
module tb_draw_sweep_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [AW-2:0] base0, base1;
  logic [AW-1:0] len0, len1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, done0, done1, busy;
  logic          stall;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b;
  logic [DW-1:0] wdata_a, wdata_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  // ctl = {busy, gnt0, gnt1, done0, done1, we_a, we_b}
  typedef struct {
    int            cyc;
    logic [6:0]    ctl;
    logic [AW-1:0] aa;
    logic [AW-1:0] ab;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];

  draw_sweep_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .base0(base0), .base1(base1),
    .len0(len0), .len1(len1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .busy(busy), .stall(stall),
    .addr_a(addr_a), .addr_b(addr_b),
    .we_a(we_a), .we_b(we_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Compare each cycle against the queued expectation, or idle if none.
  always @(negedge clk) begin
    logic [6:0] ctl;
    exp_t e;
    if (mon_en) begin
      ctl = {busy, gnt0, gnt1, done0, done1, we_a, we_b};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check_eq("sb_missed", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        $display("cyc %0d ctl %b exp %b addr_a %0d addr_b %0d wdata %0h", cyc, ctl, e.ctl, addr_a, addr_b, wdata_a);
        check_eq("ctl", ctl, e.ctl);
        if (e.ctl[0]) begin
          check_eq("addr_a", addr_a, e.aa);
          check_eq("addr_b", addr_b, e.ab);
          check_eq("wdata_a", wdata_a, e.d);
          check_eq("wdata_b", wdata_b, e.d);
        end
      end else begin
        check_eq("idle_ctl", ctl, 7'd0);
      end
    end
  end

  // Reference model: expected bus state for a job accepted at edge ending n_acc.
  task automatic push_job(input bit owner, input logic [AW-2:0] base, input logic [AW-1:0] len,
                          input logic [DW-1:0] data, input int n_acc, input int stall_off,
                          input int abort_after);
    exp_t e;
    int c, n, written;
    bit first, w;
    logic [AW-2:0] pair;
    c = n_acc + 1;
    pair = base;
    written = 0;
    n = 0;
    first = 1'b1;
    e.aa = '0;
    e.ab = '0;
    e.d = '0;
    if (len == '0) begin
      e.cyc = c;
      e.ctl = {1'b1, ~owner, owner, ~owner, owner, 2'b00};
      exp_q.push_back(e);
      return;
    end
    while (written < int'(len)) begin
      if (abort_after != 0 && n == abort_after) return;
      w = !(stall_off != 0 && c == n_acc + stall_off);
      e.cyc = c;
      e.aa = {pair, 1'b0};
      e.ab = {pair, 1'b1};
      e.d = data;
      e.ctl = {1'b1, first & ~owner, first & owner, 2'b00, w, w};
      exp_q.push_back(e);
      if (w) begin
        pair = pair + 1'b1;
        written++;
      end
      first = 1'b0;
      c++;
      n++;
    end
    e.cyc = c;
    e.ctl = {1'b1, 2'b00, ~owner, owner, 2'b00};
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      step(1);
      guard++;
    end
  endtask

  task automatic set_fields(input bit owner, input logic [AW-2:0] base, input logic [AW-1:0] len,
                            input logic [DW-1:0] data);
    if (owner) begin
      base1 = base; len1 = len; data1 = data;
    end else begin
      base0 = base; len0 = len; data0 = data;
    end
  endtask

  // One requester, DUT idle now; optional single stall at cycle n+stall_off.
  task automatic single_job(input bit owner, input logic [AW-2:0] base, input logic [AW-1:0] len,
                            input logic [DW-1:0] data, input int stall_off);
    int n;
    n = cyc;
    $display("job owner %0d base %0d len %0d data %0h stall_off %0d at cyc %0d", owner, base, len, data, stall_off, n);
    push_job(owner, base, len, data, n, stall_off, 0);
    set_fields(owner, base, len, data);
    if (owner) req1 = 1'b1; else req0 = 1'b1;
    step(1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (stall_off != 0) begin
      wait_until(n + stall_off);
      stall = 1'b1;
      step(1);
      stall = 1'b0;
    end
    wait_until(n + int'(len) + 2 + ((stall_off != 0) ? 1 : 0));
  endtask

  initial begin
    int n, m, cnt, guard;
    bit own[4];
    logic [AW-1:0] rl;
    reset = 1'b1;
    req0 = 0; req1 = 0; stall = 0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0; data0 = '0; data1 = '0;
    step(3);
    check_eq("rst_ctl", {busy, gnt0, gnt1, done0, done1, we_a, we_b}, 7'd0);
    check_eq("rst_addr_a", addr_a, 0);
    check_eq("rst_addr_b", addr_b, 0);
    check_eq("rst_wdata", {wdata_a, wdata_b}, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step(2);

    // Single job, then wrap at the top of memory with one stall.
    single_job(1'b0, 13'd1024, 14'd4, 8'hAA, 0);
    single_job(1'b1, 13'd8191, 14'd2, 8'h33, 2);

    // A few random single-requester jobs.
    for (int k = 0; k < 3; k++) begin
      rl = 14'($urandom_range(5, 1));
      single_job(1'($urandom_range(1, 0)), 13'($urandom), rl, 8'($urandom),
                 (rl > 1) ? int'($urandom_range(int'(rl), 2)) : 0);
    end

    // Zero-length job; also leaves requester 1 as last owner.
    single_job(1'b1, 13'd77, 14'd0, 8'h11, 0);

    // Contention with both requests held.
    n = cyc;
`ifdef DRAW_SWEEP_RR_EN
    cnt = 4;
    own[0] = 0; own[1] = 1; own[2] = 0; own[3] = 1;
`else
    cnt = 3;
    own[0] = 0; own[1] = 0; own[2] = 0; own[3] = 0;
`endif
    set_fields(1'b0, 13'd10, 14'd2, 8'hC0);
    set_fields(1'b1, 13'd20, 14'd2, 8'hC1);
    for (int k = 0; k < cnt; k++) begin
      push_job(own[k], own[k] ? 13'd20 : 13'd10, 14'd2, own[k] ? 8'hC1 : 8'hC0, n + 4 * k, 0, 0);
    end
    $display("contention both reqs at cyc %0d expecting %0d grants", n, cnt);
    req0 = 1'b1;
    req1 = 1'b1;
    wait_until(n + 4 * (cnt - 1) + 1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_until(n + 4 * cnt);

    // Reset during the third write of an 8-pair job owned by requester 0.
    n = cyc;
    $display("abort job at cyc %0d", n);
    push_job(1'b0, 13'd100, 14'd8, 8'h5C, n, 0, 3);
    set_fields(1'b0, 13'd100, 14'd8, 8'h5C);
    req0 = 1'b1;
    step(1);
    req0 = 1'b0;
    wait_until(n + 3);
    reset = 1'b1;
    step(1);
    check_eq("abort_addr_a", addr_a, 0);
    check_eq("abort_addr_b", addr_b, 0);
    check_eq("abort_wdata", {wdata_a, wdata_b}, 0);
    reset = 1'b0;

    // Tie right after reset: requester 0 must win.
    m = cyc;
    $display("post-reset tie at cyc %0d", m);
    push_job(1'b0, 13'd200, 14'd3, 8'h3C, m, 0, 0);
    set_fields(1'b0, 13'd200, 14'd3, 8'h3C);
    set_fields(1'b1, 13'd300, 14'd3, 8'h3D);
    req0 = 1'b1;
    req1 = 1'b1;
    step(1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_until(m + 6);

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      step(1);
      guard++;
    end
    check_eq("sb_drain", exp_q.size(), 0);
    step(1);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
